// File: rtl/bitwise_stream_unit.sv
// WIDTH-bit bitwise logic unit with a valid/ready handshake on both sides.
// It also folds framed operand streams into a single accumulated result.
module bitwise_stream_unit #(
  parameter int unsigned      WIDTH    = 4,
  parameter int unsigned      CNT_W    = 4,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             first,
  input  logic             last,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             parity,
  output logic             zero,
  output logic [CNT_W-1:0] beats
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             parity_q, parity_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             produce;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] cnt_sat;
  logic [CNT_W-1:0] frame_cnt;

  assign in_ready  = !rst && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign produce   = accept && (!acc_mode || last);
  assign operand_b = (acc_mode && !first) ? acc_q : y;
  assign cnt_sat   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
  // A frame beat without first, seen while IDLE, behaves as the frame's opening beat.
  assign frame_cnt = (first || state_q == IDLE) ? CNT_ONE : cnt_sat;

  always_comb begin
    case (op)
      OP_AND:  result = x & operand_b;
      OP_OR:   result = x | operand_b;
      OP_XOR:  result = x ^ operand_b;
      OP_XNOR: result = ~(x ^ operand_b);
      OP_NAND: result = ~(x & operand_b);
      OP_NOR:  result = ~(x | operand_b);
      OP_NOT:  result = ~x;
      default: result = x;
    endcase
  end

  // Next-state: frame tracking and the output register.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    o_d         = o_q;
    parity_d    = parity_q;
    zero_d      = zero_q;
    beats_d     = beats_q;
    out_valid_d = out_valid_q;

    if (accept && acc_mode) begin
      if (last) begin
        state_d = IDLE;
        acc_d   = ACC_INIT;
        cnt_d   = '0;
      end else begin
        state_d = ACC;
        acc_d   = result;
        cnt_d   = frame_cnt;
      end
    end

    if (produce) begin
      o_d         = result;
      parity_d    = ^result;
      zero_d      = (result == '0);
      beats_d     = acc_mode ? frame_cnt : CNT_ONE;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= ACC_INIT;
      cnt_q       <= '0;
      o_q         <= '0;
      parity_q    <= 1'b0;
      zero_q      <= 1'b0;
      beats_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      o_q         <= o_d;
      parity_q    <= parity_d;
      zero_q      <= zero_d;
      beats_q     <= beats_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign o         = o_q;
  assign parity    = parity_q;
  assign zero      = zero_q;
  assign beats     = beats_q;

endmodule

// File: tb/tb_bitwise_stream_unit.sv
// Scoreboard bench for bitwise_stream_unit: a truth-table/frame model queues expected
// results on each accept and a monitor compares them as the DUT drains its output.
module tb_bitwise_stream_unit;
  localparam int unsigned WIDTH    = 4;
  localparam int unsigned CNT_W    = 2;
  localparam logic [3:0]  ACC_INIT = 4'b0000;
  localparam int          SAT      = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = 3'd0;
  logic             acc_mode = 1'b0;
  logic             first = 1'b0;
  logic             last = 1'b0;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] o;
  logic             parity;
  logic             zero;
  logic [CNT_W-1:0] beats;

  bitwise_stream_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_INIT(ACC_INIT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .acc_mode(acc_mode), .first(first), .last(last), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .o(o), .parity(parity),
    .zero(zero), .beats(beats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] o;
    logic [CNT_W-1:0] beats;
    time              t;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Per-op truth table, indexed by {a_bit, b_bit}.
  logic [3:0] tt [8];
  bit         m_in_frame = 1'b0;
  logic [3:0] m_acc      = ACC_INIT;
  int         m_cnt      = 0;

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] opc,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] res;
    logic [3:0]       row;
    row = tt[opc];
    for (int i = 0; i < int'(WIDTH); i++) res[i] = row[{a[i], b[i]}];
    return res;
  endfunction

  task automatic push_exp(input logic [WIDTH-1:0] eo, input int c);
    exp_t e;
    e.o     = eo;
    e.beats = CNT_W'(c);
    e.t     = $time;
    sbq.push_back(e);
  endtask

  task automatic model_accept();
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    int               c;
    b = (acc_mode && !first) ? m_acc : y;
    r = apply_op(op, x, b);
    if (!acc_mode) begin
      push_exp(r, 1);
    end else begin
      if (first || !m_in_frame) c = 1;
      else c = (m_cnt + 1 > SAT) ? SAT : m_cnt + 1;
      if (last) begin
        push_exp(r, c);
        m_acc      = ACC_INIT;
        m_cnt      = 0;
        m_in_frame = 1'b0;
      end else begin
        m_acc      = r;
        m_cnt      = c;
        m_in_frame = 1'b1;
      end
    end
  endtask

  task automatic step(input bit v, input logic [2:0] opc, input bit am, input bit f,
                      input bit l, input logic [3:0] xa, input logic [3:0] ya,
                      input bit ordy, input bit r_i);
    bit exp_rdy;
    @(negedge clk);
    rst = r_i; in_valid = v; op = opc; acc_mode = am; first = f; last = l;
    x = xa; y = ya; out_ready = ordy;
    #1;
    exp_rdy = !rst && (sbq.size() == 0 || out_ready);
    checks++;
    if (in_ready !== exp_rdy) begin
      failures++;
      $display("FAIL in_ready: got %b want %b at %0t", in_ready, exp_rdy, $time);
    end
    if (rst) begin
      sbq.delete();
      m_in_frame = 1'b0;
      m_acc      = ACC_INIT;
      m_cnt      = 0;
    end else if (in_valid && in_ready) begin
      model_accept();
    end
  endtask

  task automatic plain(input logic [2:0] opc, input logic [3:0] xa, input logic [3:0] ya,
                       input bit ordy);
    step(1'b1, opc, 1'b0, 1'b0, 1'b0, xa, ya, ordy, 1'b0);
  endtask

  task automatic fbeat(input logic [2:0] opc, input bit f, input bit l,
                       input logic [3:0] xa, input logic [3:0] ya);
    step(1'b1, opc, 1'b1, f, l, xa, ya, 1'b1, 1'b0);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, ordy, 1'b0);
  endtask

  task automatic check_rst();
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || o !== '0 || parity !== 1'b0 || zero !== 1'b0 || beats !== '0) begin
      failures++;
      $display("FAIL reset_vals: got valid=%b o=%b par=%b zero=%b beats=%0d want all 0",
               out_valid, o, parity, zero, beats);
    end
  endtask

  // Monitor: sample between edges, pop on every drain.
  initial begin : monitor
    exp_t             e;
    bit               prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_o;
    logic             prev_par, prev_zero;
    logic [CNT_W-1:0] prev_beats;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          checks++;
          if (out_valid !== 1'b1 || o !== prev_o || parity !== prev_par ||
              zero !== prev_zero || beats !== prev_beats) begin
            failures++;
            $display("FAIL stall_stable: got valid=%b o=%b beats=%0d want valid=1 o=%b beats=%0d",
                     out_valid, o, beats, prev_o, prev_beats);
          end
        end
        if (out_valid === 1'b1) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_valid: got out_valid=1 o=%b want no result", o);
          end else if (out_ready) begin
            e = sbq.pop_front();
            checks++;
            if (o !== e.o || parity !== ^e.o || zero !== (e.o == '0) || beats !== e.beats) begin
              failures++;
              $display("FAIL result: got o=%b par=%b zero=%b beats=%0d want o=%b par=%b zero=%b beats=%0d",
                       o, parity, zero, beats, e.o, ^e.o, (e.o == '0), e.beats);
            end
          end
        end else if (sbq.size() > 0 && ($time - sbq[0].t) > 5) begin
          e = sbq.pop_front();
          checks++;
          failures++;
          $display("FAIL latency: got out_valid=0 want result o=%b", e.o);
        end
        prev_hold  = out_valid && !out_ready;
        prev_o     = o;
        prev_par   = parity;
        prev_zero  = zero;
        prev_beats = beats;
      end
    end
  end

  initial begin : driver
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b1001;
    tt[4] = 4'b0111; tt[5] = 4'b0001; tt[6] = 4'b0011; tt[7] = 4'b1100;

    // Reset with an offered beat that must be ignored.
    step(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1);
    check_rst();

    // Every op on x=0101, y=0011.
    for (int k = 0; k < 8; k++) plain(3'(k), 4'b0101, 4'b0011, 1'b1);
    idle(1'b1);

    // XOR frame, then a frame without first starting from ACC_INIT.
    fbeat(3'd2, 1'b1, 1'b0, 4'b1010, 4'b0000);
    fbeat(3'd2, 1'b0, 1'b0, 4'b0110, 4'b1111);
    fbeat(3'd2, 1'b0, 1'b1, 4'b0011, 4'b1111);
    fbeat(3'd2, 1'b0, 1'b0, 4'b0001, 4'b1111);
    fbeat(3'd2, 1'b0, 1'b1, 4'b0010, 4'b1111);
    idle(1'b1);

    // Backpressure: held result, refused beats, then accept-with-drain.
    plain(3'd2, 4'b0101, 4'b0011, 1'b0);
    for (int k = 0; k < 5; k++) plain(3'd2, 4'b1111, 4'b1111, 1'b0);
    plain(3'd2, 4'b1111, 4'b1111, 1'b1);
    idle(1'b1);

    // Interleaved plain beat, then a restarting frame.
    fbeat(3'd2, 1'b1, 1'b0, 4'b1111, 4'b0000);
    plain(3'd0, 4'b1100, 4'b1010, 1'b1);
    fbeat(3'd2, 1'b1, 1'b0, 4'b0001, 4'b0000);
    fbeat(3'd2, 1'b0, 1'b1, 4'b0001, 4'b0000);
    idle(1'b1);

    // Beat-count saturation on a 5-beat OR frame.
    fbeat(3'd1, 1'b1, 1'b0, 4'b0001, 4'b0000);
    fbeat(3'd1, 1'b0, 1'b0, 4'b0010, 4'b0000);
    fbeat(3'd1, 1'b0, 1'b0, 4'b0100, 4'b0000);
    fbeat(3'd1, 1'b0, 1'b0, 4'b1000, 4'b0000);
    fbeat(3'd1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    idle(1'b1);

    // Reset mid-frame with a pending result, then a one-beat frame.
    fbeat(3'd2, 1'b1, 1'b0, 4'b0110, 4'b0000);
    plain(3'd2, 4'b0101, 4'b0011, 1'b0);
    idle(1'b0);
    step(1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1);
    check_rst();
    fbeat(3'd2, 1'b1, 1'b1, 4'b1100, 4'b0101);
    idle(1'b1);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      step(($urandom_range(9) < 7), 3'($urandom_range(7)), ($urandom_range(1) == 1),
           ($urandom_range(9) < 3), ($urandom_range(9) < 3), 4'($urandom), 4'($urandom),
           ($urandom_range(9) < 7), ($urandom_range(99) == 0));
    end

    for (int k = 0; k < 4; k++) idle(1'b1);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain_empty: got %0d pending want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
